// File: rtl/conv_drv_pkg.sv
// Shared types and constants for the convolution tile driver.
// Optional engine-timeout logic is enabled with the CONV_DRV_TIMEOUT_EN macro.
package conv_drv_pkg;

    localparam int N_W   = 9;
    localparam int N_IN  = 16;
    localparam int N_OUT = 4;
    localparam int CNT_W = 5;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [7:0]       byte_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_IN = 3'd2,
        S_ENG_WL  = 3'd3,
        S_START   = 3'd4,
        S_WAIT    = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

endpackage

// File: rtl/conv_tile_driver_if.sv
// Byte-stream bundle between the tile-fetch side and the driver: input tile bytes
// in, result bytes out. The master modport is the host view, slave is the driver.
interface conv_tile_driver_if;
    import conv_drv_pkg::*;

    // Both channels: a byte transfers on a clock edge where valid && ready are high;
    // the producer keeps valid and payload stable until then and never waits for ready.
    logic  s_valid;
    logic  s_ready;
    byte_t s_data;
    logic  frame_wload;
    logic  m_valid;
    logic  m_ready;
    byte_t m_data;
    logic  m_last;

    modport master (
        output s_valid, s_data, frame_wload, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, frame_wload, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/conv_drv_outser.sv
// Result register and 4-byte valid/ready serializer; out_11 goes first and
// m_last marks out_22. empty_done pulses on the final byte's handshake.
module conv_drv_outser
    import conv_drv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data,
    input  logic        m_ready,
    output logic        m_valid,
    output byte_t       m_data,
    output logic        m_last,
    output logic        empty_done
);

    logic [31:0] res_q;
    logic [1:0]  idx_q;
    logic        valid_q;
    logic        fire;

    assign fire       = valid_q && m_ready;
    assign m_last     = valid_q && (idx_q == 2'(N_OUT - 1));
    assign empty_done = fire && m_last;
    assign m_valid    = valid_q;
    assign m_data     = valid_q ? res_q[{idx_q, 3'b000} +: 8] : '0;

    // idx_q wraps back to 0 after the last byte, ready for the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            res_q   <= data;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (fire) begin
            idx_q <= idx_q + 2'd1;
            if (empty_done) valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_tile_driver.sv
// Host-side driver for the 2x2-output convolution engine: loads weights/pixels,
// sequences weight_load/start/done, streams the four results. Macro: CONV_DRV_TIMEOUT_EN.
module conv_tile_driver
    import conv_drv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)(
    input  logic                 clk,
    input  logic                 rst,
    conv_tile_driver_if.slave    bus,
    output logic                 eng_weight_load,
    output logic [8*N_W-1:0]     eng_w,
    output logic [8*N_IN-1:0]    eng_in,
    output logic                 eng_start,
    input  logic                 eng_done,
    input  logic [8*N_OUT-1:0]   eng_out,
    output logic                 busy,
    output logic                 err_timeout,
    output state_t               state_dbg
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    cnt_t        wr_idx;
    logic        run_q;
    logic        s_fire, w_wr, in_wr;
    logic        res_load, tmo_hit, drain_done;
    logic [31:0] res_data;

    // run_q keeps s_ready low while reset is held and for the edge that releases it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    assign bus.s_ready = run_q && (state_q inside {S_IDLE, S_LOAD_W, S_LOAD_IN});
    assign s_fire      = bus.s_valid && bus.s_ready;
    assign wr_idx      = (state_q == S_IDLE) ? '0 : cnt_q;
    assign w_wr  = s_fire && ((state_q == S_LOAD_W)  || (state_q == S_IDLE &&  bus.frame_wload));
    assign in_wr = s_fire && ((state_q == S_LOAD_IN) || (state_q == S_IDLE && !bus.frame_wload));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_load = 1'b0;
        res_data = eng_out;
        case (state_q)
            S_IDLE: if (s_fire) begin
                state_d = bus.frame_wload ? S_LOAD_W : S_LOAD_IN;
                cnt_d   = cnt_t'(1);
            end
            S_LOAD_W: if (s_fire) begin
                if (cnt_q == cnt_t'(N_W - 1)) begin
                    state_d = S_ENG_WL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            S_ENG_WL: begin
                state_d = S_LOAD_IN;
                cnt_d   = '0;
            end
            S_LOAD_IN: if (s_fire) begin
                if (cnt_q == cnt_t'(N_IN - 1)) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            S_START: state_d = S_WAIT;
            // A done arriving on the expiry cycle takes priority over the timeout.
            S_WAIT: begin
                if (eng_done) begin
                    res_load = 1'b1;
                    state_d  = S_DRAIN;
                end else if (tmo_hit) begin
                    res_load = 1'b1;
                    res_data = '0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: if (drain_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            eng_w   <= '0;
            eng_in  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < N_W; i++)
                if (w_wr && wr_idx == cnt_t'(i)) eng_w[i*8 +: 8] <= bus.s_data;
            for (int i = 0; i < N_IN; i++)
                if (in_wr && wr_idx == cnt_t'(i)) eng_in[i*8 +: 8] <= bus.s_data;
        end
    end

`ifdef CONV_DRV_TIMEOUT_EN
    logic [15:0] wait_cnt_q;
    logic        err_q;

    assign tmo_hit = (state_q == S_WAIT) && !eng_done &&
                     (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 16'd1 : '0;
            if (tmo_hit) err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    conv_drv_outser u_outser (
        .clk        (clk),
        .rst        (rst),
        .load       (res_load),
        .data       (res_data),
        .m_ready    (bus.m_ready),
        .m_valid    (bus.m_valid),
        .m_data     (bus.m_data),
        .m_last     (bus.m_last),
        .empty_done (drain_done)
    );

    assign eng_weight_load = (state_q == S_ENG_WL);
    assign eng_start       = (state_q == S_START);
    assign busy            = (state_q != S_IDLE);
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_conv_tile_driver.sv
// Directed bench for conv_tile_driver: a frame-level model tracks accepted bytes,
// expected pulse cycles and the result byte queue; literal checks pin that model.
module tb_conv_tile_driver;
    import conv_drv_pkg::*;

    localparam int TMO = 8;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         eng_done = 1'b0;
    logic [31:0]  eng_out = '0;
    logic         eng_weight_load, eng_start, busy, err_timeout;
    logic [71:0]  eng_w;
    logic [127:0] eng_in;
    state_t       state_dbg;

    conv_tile_driver_if bus();

    conv_tile_driver #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .eng_weight_load (eng_weight_load),
        .eng_w           (eng_w),
        .eng_in          (eng_in),
        .eng_start       (eng_start),
        .eng_done        (eng_done),
        .eng_out         (eng_out),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / model state ----------------
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  model_w[9];
    logic [7:0]  model_in[16];
    logic [7:0]  fbuf[25];
    int          pos = 0;
    logic        fr_wl = 1'b0;
    int          exp_wl_cyc = -10;
    int          exp_start_cyc = -10;
    int          wl_pulses = 0;
    logic        err_exp = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    int          stall_mode = 0;
    int          stall_lo = 0;
    int          d_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [71:0] pack_w();
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = model_w[i];
        return r;
    endfunction

    function automatic logic [127:0] pack_in();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = model_in[i];
        return r;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 9; i++) model_w[i] = '0;
                for (int i = 0; i < 16; i++) model_in[i] = '0;
                pos = 0;
                exp_wl_cyc = -10;
                exp_start_cyc = -10;
                err_exp = 1'b0;
                prev_stall = 1'b0;
                exp_q.delete();
            end else begin
                check("eng_w", eng_w, pack_w());
                check("err_timeout", err_timeout, err_exp);
                check("eng_weight_load", eng_weight_load, cyc == exp_wl_cyc);
                check("eng_start", eng_start, cyc == exp_start_cyc);
                if (eng_start) check("eng_in", eng_in, pack_in());
                if (cyc == exp_wl_cyc || cyc == exp_start_cyc) check("s_ready_blocked", bus.s_ready, 1'b0);
                if (eng_weight_load) wl_pulses++;
                if (prev_stall) begin
                    check("m_valid_hold", bus.m_valid, 1'b1);
                    check("m_data_hold", bus.m_data, prev_data);
                    check("m_last_hold", bus.m_last, prev_last);
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("FAIL m_byte_extra: got %0h, required no byte", {bus.m_last, bus.m_data});
                    end else begin
                        check("m_byte", {bus.m_last, bus.m_data}, exp_q.pop_front());
                    end
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
                prev_last  = bus.m_last;
                if (bus.s_valid && bus.s_ready) begin
                    if (pos == 0) fr_wl = bus.frame_wload;
                    if (fr_wl && pos < 9) model_w[pos] = bus.s_data;
                    else model_in[pos - (fr_wl ? 9 : 0)] = bus.s_data;
                    pos++;
                    if (fr_wl && pos == 9) exp_wl_cyc = cyc + 1;
                    if (pos == (fr_wl ? 25 : 16)) begin
                        pos = 0;
                        exp_start_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    // ---------------- result sink (m_ready) ----------------
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_mode == 0) begin
                bus.m_ready = 1'b1;
                stall_lo = 0;
            end else if (!bus.m_valid) begin
                bus.m_ready = 1'b0;
                stall_lo = 0;
            end else if (stall_lo < 5) begin
                bus.m_ready = 1'b0;
                stall_lo++;
            end else begin
                bus.m_ready = 1'b1;
                stall_lo = 0;
            end
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic send_byte(input logic [7:0] b, input logic wl, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data = b;
        bus.frame_wload = wl;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            n++;
            if (n > 200) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL s_accept: s_ready stayed 0 for %0d cycles, required 1", n);
                break;
            end
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_range(input logic wl, input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) send_byte(fbuf[i], wl, gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    // Called in the START cycle; answers 'delay' cycles into WAIT.
    task automatic engine_done(input logic [31:0] val, input int delay, input bit spur);
        if (spur) begin
            eng_done = 1'b1;
            eng_out = 32'hDEADBEEF;
        end
        @(posedge clk); #1;
        eng_done = 1'b0;
        repeat (delay) begin @(posedge clk); #1; end
        eng_done = 1'b1;
        eng_out = val;
        d_cyc = cyc;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3) ? 1'b1 : 1'b0, val[8*k +: 8]});
        @(posedge clk); #1;
        eng_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 300);
        if (n >= 300) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL wait_idle: busy=%0d pending=%0d after 300 cycles, required 0/0", busy, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.frame_wload = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_outputs", {eng_weight_load, eng_start, bus.m_valid, bus.m_last, busy, err_timeout}, 6'b0);
        check("rst_buses", {eng_w, eng_in, bus.m_data}, '0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rel_s_ready", bus.s_ready, 1'b1);
        check("rel_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Frame A: weights 1..9, pixels 1..16.
        for (int i = 0; i < 9; i++) fbuf[i] = 8'(i + 1);
        for (int i = 0; i < 16; i++) fbuf[9 + i] = 8'(i + 1);
        send_range(1'b1, 0, 25, 1'b0);
        check("a_w11", eng_w[7:0], 8'd1);
        check("a_w33", eng_w[71:64], 8'd9);
        check("a_busy", busy, 1'b1);
        engine_done(32'h44332211, 2, 1'b0);
        @(negedge clk);
        check("a_d1_valid", bus.m_valid, 1'b1);
        check("a_d1_data", bus.m_data, 8'h11);
        repeat (3) @(negedge clk);
        check("a_d4_data", bus.m_data, 8'h44);
        check("a_d4_last", bus.m_last, 1'b1);
        check("a_d4_busy", busy, 1'b1);
        @(negedge clk);
        check("a_d5_busy", busy, 1'b0);
        check("a_d5_s_ready", bus.s_ready, 1'b1);
        check("a_wl_pulses", wl_pulses, 1);
        @(posedge clk); #1;

        // Frame B: pixels only, all 0xFF; weights must survive.
        for (int i = 0; i < 16; i++) fbuf[i] = 8'hFF;
        send_range(1'b0, 0, 16, 1'b0);
        check("b_w_kept", eng_w, 72'h090807060504030201);
        check("b_in", eng_in, {16{8'hFF}});
        engine_done(32'h01020304, 0, 1'b0);
        wait_idle();
        check("b_wl_pulses", wl_pulses, 1);

        // Frame C: input gaps, output stalls, stray done pulses in LOAD_IN and START.
        stall_mode = 1;
        for (int i = 0; i < 9; i++) fbuf[i] = 8'(8'h10 + i);
        for (int i = 9; i < 25; i++) fbuf[i] = 8'($urandom_range(0, 255));
        send_range(1'b1, 0, 20, 1'b1);
        eng_done = 1'b1;
        eng_out = 32'hDEADBEEF;
        @(posedge clk); #1;
        eng_done = 1'b0;
        send_range(1'b1, 20, 25, 1'b1);
        engine_done(32'hA5C37E18, 3, 1'b1);
        check("c_in_hold", eng_in, pack_in());
        wait_idle();
        stall_mode = 0;
        check("c_wl_pulses", wl_pulses, 2);

        // Reset after 12 bytes, then a full frame.
        for (int i = 0; i < 25; i++) fbuf[i] = 8'(8'h40 + 3 * i);
        send_range(1'b1, 0, 12, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_s_ready", bus.s_ready, 1'b0);
        check("mid_rst_outputs", {eng_weight_load, eng_start, bus.m_valid, bus.m_last, busy, err_timeout}, 6'b0);
        check("mid_rst_buses", {eng_w, eng_in, bus.m_data}, '0);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send_range(1'b1, 0, 25, 1'b0);
        engine_done(32'h87654321, 1, 1'b0);
        wait_idle();
        check("d_w_first", eng_w[7:0], 8'h40);

`ifdef CONV_DRV_TIMEOUT_EN
        // Engine never answers: timeout after TMO WAIT cycles, four zero bytes out.
        for (int i = 0; i < 16; i++) fbuf[i] = 8'(3 * i);
        send_range(1'b0, 0, 16, 1'b0);
        repeat (TMO) begin @(posedge clk); #1; end
        @(negedge clk);
        check("t_err_before", err_timeout, 1'b0);
        @(posedge clk); #1;
        err_exp = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3) ? 1'b1 : 1'b0, 8'h00});
        @(negedge clk);
        check("t_err_set", err_timeout, 1'b1);
        check("t_zero_byte", bus.m_data, 8'h00);
        @(posedge clk); #1;
        wait_idle();
        for (int i = 0; i < 16; i++) fbuf[i] = 8'(8'h80 + i);
        send_range(1'b0, 0, 16, 1'b0);
        engine_done(32'h0A0B0C0D, 0, 1'b0);
        wait_idle();
        check("t_err_sticky", err_timeout, 1'b1);
`endif

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_tile_driver.md
# conv_tile_driver

Host-side driver for the 2x2-output convolution engine. Accepts a byte stream carrying an optional 3x3 weight set and a 4x4 input tile, holds them on the engine's parallel buses, and issues the engine's `weight_load`/`start` controls. It then waits for `done`, captures the four results, and returns them as a 4-byte output stream. It sits between the tile-fetch DMA and the convolution engine.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum WAIT duration before abort. Used only with `CONV_DRV_TIMEOUT_EN`. Range 1..65535.

Ports:
- `clk`: input, 1 bit. Single clock domain.
- `rst`: input, 1 bit. Reset, asynchronous, active-low.
- `s_valid`: input, 1 bit. Input byte valid.
- `s_ready`: output, 1 bit. Input byte ready.
- `s_data`: input, 8 bits. Input byte.
- `frame_wload`: input, 1 bit. Sampled with a frame's first byte. When 1, the frame is 9 weight bytes followed by 16 pixels (25 bytes). When 0, the frame is 16 pixels only.
- `eng_weight_load`: output, 1 bit. One-cycle weight-load pulse to the engine.
- `eng_w`: output, 72 bits. Weights w_11..w_33 packed row-major, w_11 in [7:0].
- `eng_in`: output, 128 bits. Pixels in_11..in_44 packed row-major, in_11 in [7:0].
- `eng_start`: output, 1 bit. One-cycle start pulse.
- `eng_done`: input, 1 bit. Engine completion.
- `eng_out`: input, 32 bits. Results {out_22, out_21, out_12, out_11}.
- `m_valid`: output, 1 bit. Result byte valid.
- `m_ready`: input, 1 bit. Result byte ready.
- `m_data`: output, 8 bits. Result byte.
- `m_last`: output, 1 bit. High on the 4th result byte.
- `busy`: output, 1 bit. High whenever the state is not IDLE.
- `err_timeout`: output, 1 bit. Sticky engine-timeout flag.

## Operation
- FSM states: IDLE, LOAD_W, LOAD_IN, ENG_WL, START, WAIT, DRAIN.
- IDLE: `s_ready`=1. On the first handshake, latch `frame_wload`.
  - If it is 1, the byte is w_11 and the state goes to LOAD_W with count 1.
  - If it is 0, the byte is in_11 and the state goes to LOAD_IN with count 1.
- LOAD_W: capture bytes into `eng_w` in row-major order. After the 9th byte, go to ENG_WL.
- ENG_WL: `eng_weight_load`=1 for exactly one cycle, `s_ready`=0. Then go to LOAD_IN with count 0.
- LOAD_IN: capture bytes into `eng_in` in row-major order. After the 16th byte, go to START.
- START: `eng_start`=1 for exactly one cycle. Then go to WAIT.
- WAIT: on `eng_done`=1, capture `eng_out` into the result register and go to DRAIN.
- DRAIN: present the results in order out_11, out_12, out_21, out_22, advancing on each `m_valid && m_ready`. `m_last`=1 with out_22. After the 4th handshake, return to IDLE.
- `s_ready`=1 only in IDLE, LOAD_W and LOAD_IN.
- `eng_w` persists across frames. It changes only in LOAD_W. It is 0 after reset.
- `eng_in` is held stable from START through the end of WAIT.
- `eng_done` is ignored in every state except WAIT.
- Backpressure: while `m_ready`=0, `m_data` and `m_last` hold their values.
- An input stall (`s_valid`=0) mid-frame simply pauses the load; there is no frame timeout on input.

## Timing
- Reset (while `rst`=0): state=IDLE.
  - `s_ready`=0 during reset and 1 on the first cycle after release.
  - All other outputs are 0: `eng_weight_load`, `eng_w`, `eng_in`, `eng_start`, `m_valid`, `m_data`, `m_last`, `busy`, `err_timeout`.
- Reset asserted mid-operation discards the partial frame and captured results. It clears weights and the error flag.
- 9th weight accepted in cycle N: `eng_weight_load` is high in cycle N+1 and the 16-pixel load can begin in N+2.
- 16th pixel accepted in cycle N: `eng_start` is high in cycle N+1.
- `eng_done` sampled high in cycle D: `m_valid` is high with out_11 in cycle D+1.
- Minimum output latency with `m_ready` held at 1: 4 cycles D+1..D+4. The next frame is accepted from D+5.
- `eng_done` high in the same cycle as `eng_start` is ignored; it is sampled from the first WAIT cycle onward.

## Configuration
- Macro `CONV_DRV_TIMEOUT_EN`.
- Defined:
  - WAIT has a cycle counter. If `TIMEOUT_CYCLES` cycles elapse in WAIT without `eng_done`, set `err_timeout`, load the result register with zeros, and go to DRAIN (four 0x00 bytes, `m_last` on the 4th).
  - `err_timeout` stays set until reset.
  - If `eng_done` arrives in the same cycle the count expires, `eng_done` wins and no error is raised.
- Not defined: WAIT waits indefinitely, `err_timeout` is tied to 0, and there is no counter logic.

## Structure
- Package `conv_drv_pkg`:
  - FSM state encoding.
  - Constants N_W=9, N_IN=16, N_OUT=4.
  - Byte-count width (5 bits).
- Sub-module `conv_drv_outser`: 32-bit result register plus 4-byte valid/ready serializer with `m_last` generation. It loads on a single-cycle `load` strobe and pulses `empty_done` when the 4th byte handshakes.

## Test plan
- Weights 1..9 and pixels 1..16 with `frame_wload`=1:
  - `eng_weight_load` pulses exactly once, 1 cycle after the 9th byte.
  - `eng_w[7:0]`=1 and `eng_w[71:64]`=9.
  - `eng_start` pulses 1 cycle after the 16th byte.
  - A model engine returning `eng_out`=0x44332211 yields `m_data` 0x11, 0x22, 0x33, 0x44, with `m_last` on 0x44.
- A second frame with `frame_wload`=0 and pixels 0xFF: no `eng_weight_load` pulse, `eng_w` is unchanged from the previous frame, and exactly 16 bytes are accepted.
- Random `s_valid` gaps and `m_ready` held low for 5 cycles per byte: byte order is unchanged and `m_data` stays stable while stalled.
- `eng_done` pulsed during LOAD_IN and again in the START cycle: both are ignored, and results are captured only from the `eng_done` pulse in WAIT.
- `rst` asserted after 12 input bytes: all outputs go to 0 immediately. After release, a full 25-byte frame completes normally.
- With `CONV_DRV_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, engine never asserts done:
  - `err_timeout` sets after 8 WAIT cycles.
  - Four 0x00 bytes are output.
  - `err_timeout` stays at 1 through the next successful frame.
